// File: rtl/core_memory_pkg.sv
// Shared types for the core memory router: FSM states, access sizes and mask encodings.
package core_memory_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SRAM_WAIT,
    ST_WB_WAIT,
    ST_RESP
  } state_t;

  typedef enum logic [1:0] {
    SZ_NONE,
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } size_t;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  // Any mask outside the three legal encodings (including zero) maps to SZ_NONE.
  function automatic size_t mask_to_size(input logic [3:0] mask);
    case (mask)
      MASK_BYTE: return SZ_BYTE;
      MASK_HALF: return SZ_HALF;
      MASK_WORD: return SZ_WORD;
      default:   return SZ_NONE;
    endcase
  endfunction

endpackage

// File: rtl/core_memory_router_lane_aligner.sv
// Combinational byte-lane alignment: shifts store mask/data up to the addressed lane,
// shifts load data down and extends it, and flags illegal or misaligned requests.
module lane_aligner
  import core_memory_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [3:0]  load_mask,
  input  logic [3:0]  store_mask,
  input  logic        load_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic        req,
  output logic        is_store,
  output logic        bad,
  output logic [3:0]  lane_mask,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [3:0]  mask;
  size_t       size;
  logic [4:0]  shamt;
  logic [31:0] rshift;

  always_comb begin
    is_store   = |store_mask;
    req        = (|load_mask) | is_store;
    mask       = is_store ? store_mask : load_mask;
    size       = mask_to_size(mask);
    shamt      = {addr_lo, 3'b000};
    bad        = ((|load_mask) && is_store) ||
                 (req && size == SZ_NONE) ||
                 (size == SZ_HALF && addr_lo[0]) ||
                 (size == SZ_WORD && addr_lo != 2'b00);
    lane_mask  = mask << addr_lo;
    wdata_lane = wdata << shamt;
    rshift     = rdata_raw >> shamt;
    case (mask_to_size(load_mask))
      SZ_BYTE: rdata_ext = {{24{load_signed & rshift[7]}}, rshift[7:0]};
      SZ_HALF: rdata_ext = {{16{load_signed & rshift[15]}}, rshift[15:0]};
      default: rdata_ext = rshift;
    endcase
  end

endmodule

// File: rtl/core_memory_router.sv
// Single-outstanding memory router between the RV32I core port and local SRAM / Wishbone peripherals.
// SRAM accesses complete in 2 cycles; Wishbone accesses wait for ack/err or a saturating timeout.
module core_memory_router
  import core_memory_pkg::*;
#(
  parameter int          SRAM_ADDR_BITS = 10,
  parameter logic [31:0] SRAM_BASE      = 32'h0000_0000,
  parameter logic [3:0]  WB_BASE_NIBBLE = 4'h1,
  parameter int          WB_TIMEOUT     = 255
) (
  input  logic                      clk,
  input  logic                      nrst,
  input  logic [31:0]               coreAddress,
  input  logic [3:0]                coreLoadMask,
  input  logic [3:0]                coreStoreMask,
  input  logic                      coreLoadSigned,
  input  logic [31:0]               coreWriteData,
  output logic [31:0]               coreReadData,
  output logic                      coreReady,
  output logic                      coreError,
  output logic                      sram_csb,
  output logic                      sram_web,
  output logic [3:0]                sram_wmask,
  output logic [SRAM_ADDR_BITS-1:0] sram_addr,
  output logic [31:0]               sram_din,
  input  logic [31:0]               sram_dout,
  output logic                      wb_cyc_o,
  output logic                      wb_stb_o,
  output logic                      wb_we_o,
  output logic [3:0]                wb_sel_o,
  output logic [31:0]               wb_adr_o,
  output logic [31:0]               wb_dat_o,
  input  logic [31:0]               wb_dat_i,
  input  logic                      wb_ack_i,
  input  logic                      wb_err_i
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(WB_TIMEOUT);

  state_t      state, state_n;
  logic [7:0]  wb_cnt;
  logic [31:0] resp_data;
  logic        resp_err;

  logic        req, is_store, bad;
  logic [3:0]  lane_mask;
  logic [31:0] wdata_lane, rdata_ext, rdata_raw;
  logic        sram_hit, wb_hit, idle_err, idle_sram, idle_wb, wb_timeout;

  assign rdata_raw = (state == ST_SRAM_WAIT) ? sram_dout : wb_dat_i;

  lane_aligner u_lane_aligner (
    .addr_lo     (coreAddress[1:0]),
    .load_mask   (coreLoadMask),
    .store_mask  (coreStoreMask),
    .load_signed (coreLoadSigned),
    .wdata       (coreWriteData),
    .rdata_raw   (rdata_raw),
    .req         (req),
    .is_store    (is_store),
    .bad         (bad),
    .lane_mask   (lane_mask),
    .wdata_lane  (wdata_lane),
    .rdata_ext   (rdata_ext)
  );

  // SRAM decode wins when the two regions overlap.
  assign sram_hit   = coreAddress[31:SRAM_ADDR_BITS+2] == SRAM_BASE[31:SRAM_ADDR_BITS+2];
  assign wb_hit     = coreAddress[31:28] == WB_BASE_NIBBLE;
  assign idle_err   = req && (bad || !(sram_hit || wb_hit));
  assign idle_sram  = req && !bad && sram_hit;
  assign idle_wb    = req && !bad && !sram_hit && wb_hit;
  assign wb_timeout = wb_cnt == TIMEOUT_CNT;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      state     <= ST_IDLE;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_sel_o  <= 4'b0000;
      wb_adr_o  <= 32'h0;
      wb_dat_o  <= 32'h0;
      wb_cnt    <= 8'h0;
      resp_data <= 32'h0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        ST_IDLE: begin
          if (idle_err) begin
            resp_err  <= 1'b1;
            resp_data <= 32'h0;
          end else if (idle_wb) begin
            wb_cyc_o <= 1'b1;
            wb_stb_o <= 1'b1;
            wb_we_o  <= is_store;
            wb_sel_o <= lane_mask;
            wb_adr_o <= {coreAddress[31:2], 2'b00};
            wb_dat_o <= wdata_lane;
            wb_cnt   <= 8'h0;
          end
        end
        ST_WB_WAIT: begin
          // err beats ack; ack beats a timeout landing in the same cycle.
          if (wb_err_i || (!wb_ack_i && wb_timeout)) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            resp_err  <= 1'b1;
            resp_data <= 32'h0;
          end else if (wb_ack_i) begin
            wb_cyc_o  <= 1'b0;
            wb_stb_o  <= 1'b0;
            resp_err  <= 1'b0;
            resp_data <= is_store ? 32'h0 : rdata_ext;
          end else begin
            wb_cnt <= wb_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_n      = state;
    sram_csb     = 1'b1;
    sram_web     = 1'b1;
    sram_wmask   = 4'b0000;
    sram_addr    = coreAddress[SRAM_ADDR_BITS+1:2];
    sram_din     = wdata_lane;
    coreReady    = 1'b0;
    coreError    = 1'b0;
    coreReadData = 32'h0;
    case (state)
      ST_IDLE: begin
        if (idle_err) begin
          state_n = ST_RESP;
        end else if (idle_sram) begin
          sram_csb   = 1'b0;
          sram_web   = !is_store;
          sram_wmask = is_store ? lane_mask : 4'b0000;
          state_n    = ST_SRAM_WAIT;
        end else if (idle_wb) begin
          state_n = ST_WB_WAIT;
        end
      end
      ST_SRAM_WAIT: begin
        coreReady    = 1'b1;
        coreReadData = is_store ? 32'h0 : rdata_ext;
        state_n      = ST_IDLE;
      end
      ST_WB_WAIT: begin
        if (wb_err_i || wb_ack_i || wb_timeout) state_n = ST_RESP;
      end
      ST_RESP: begin
        coreReady    = 1'b1;
        coreError    = resp_err;
        coreReadData = resp_data;
        state_n      = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
